// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART serial engine.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_ODD  = 2'b01,
    PAR_EVEN = 2'b10
  } uart_parity_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } uart_tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } uart_rx_state_t;

  // Mode 2'b11 is reserved and behaves as no parity.
  function automatic uart_parity_t decode_parity(input logic [1:0] mode);
    case (mode)
      2'b01:   return PAR_ODD;
      2'b10:   return PAR_EVEN;
      default: return PAR_NONE;
    endcase
  endfunction

  // Parity bit for a character whose data bits reduce-XOR to data_xor.
  function automatic logic parity_bit(input uart_parity_t mode, input logic data_xor);
    return (mode == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running oversample tick generator, one tick every div+1 clocks.
module uart_baud_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt;

  // >= keeps the counter bounded if the divisor is lowered while running.
  assign tick = (cnt >= div);

  // Count 0..div and wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_serdes.sv
// uart_serdes: UART TX/RX engine with selectable parity, 1/2 stop bits, 16x oversampling.
//
//   state      | meaning
//   TX_IDLE    | line high, tx_ready when enabled
//   TX_START   | driving start bit (0)
//   TX_DATA    | driving data bits LSB first
//   TX_PARITY  | driving parity bit
//   TX_STOP    | driving one or two stop bits (1)
//   RX_IDLE    | waiting for a falling edge
//   RX_START   | half-bit wait, then start bit re-check
//   RX_DATA    | sampling data bits at bit centres
//   RX_PARITY  | sampling parity bit
//   RX_STOP    | sampling first stop bit, then deliver or drop
module uart_serdes
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_tx_enable,
  input  logic                  cfg_rx_enable,
  input  logic [1:0]            cfg_parity,
  input  logic                  cfg_stop2,
  input  logic [DIV_WIDTH-1:0]  cfg_baud_div,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_busy,
  output logic                  txd,
  input  logic                  rxd,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_parity_err,
  output logic                  rx_frame_err,
  output logic                  rx_overrun,
  output logic                  rx_busy
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_WIDTH - 1);
  localparam logic [4:0]    TICKS_BIT   = 5'(OVERSAMPLE - 1);
  localparam logic [4:0]    TICKS_STOP2 = 5'(2 * OVERSAMPLE - 1);
  localparam logic [4:0]    TICKS_HALF  = 5'(OVERSAMPLE / 2 - 1);

  logic           tick;
  uart_parity_t   par_mode;
  logic [4:0]     stop_ticks;

  uart_tx_state_t  tx_state;
  logic            tx_idle;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic            tx_par;
  logic [4:0]      tx_cnt;
  logic [BW-1:0]   tx_bit;

  uart_rx_state_t  rx_state;
  logic            rxd_meta, rxd_sync, rxd_prev, rx_fall;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic            rx_perr;
  logic [4:0]      rx_cnt;
  logic [BW-1:0]   rx_bit;

  uart_baud_gen #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .div   (cfg_baud_div),
    .tick  (tick)
  );

  assign par_mode   = decode_parity(cfg_parity);
  assign stop_ticks = cfg_stop2 ? TICKS_STOP2 : TICKS_BIT;

  // tx_idle is registered so tx_ready stays low during and right after reset.
  assign tx_ready = tx_idle && cfg_tx_enable;
  assign tx_busy  = (tx_state != TX_IDLE);
  assign rx_busy  = (rx_state != RX_IDLE);
  assign rx_fall  = rxd_prev & ~rxd_sync;

  // TX FSM: each state holds for 16 ticks (stop for 16 or 32), txd registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_idle  <= 1'b0;
      txd      <= 1'b1;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_idle <= 1'b1;
          if (tx_ready && tx_valid) begin
            tx_state <= TX_START;
            tx_idle  <= 1'b0;
            txd      <= 1'b0;
            tx_shift <= tx_data;
            tx_par   <= parity_bit(par_mode, ^tx_data);
            tx_cnt   <= TICKS_BIT;
          end
        end
        default: begin
          if (tick) begin
            if (tx_cnt != '0) begin
              tx_cnt <= tx_cnt - 1'b1;
            end else begin
              tx_cnt <= TICKS_BIT;
              case (tx_state)
                TX_START: begin
                  tx_state <= TX_DATA;
                  txd      <= tx_shift[0];
                  tx_bit   <= BIT_LAST;
                end
                TX_DATA: begin
                  if (tx_bit != '0) begin
                    tx_bit   <= tx_bit - 1'b1;
                    tx_shift <= tx_shift >> 1;
                    txd      <= tx_shift[1];
                  end else if (par_mode != PAR_NONE) begin
                    tx_state <= TX_PARITY;
                    txd      <= tx_par;
                  end else begin
                    tx_state <= TX_STOP;
                    txd      <= 1'b1;
                    tx_cnt   <= stop_ticks;
                  end
                end
                TX_PARITY: begin
                  tx_state <= TX_STOP;
                  txd      <= 1'b1;
                  tx_cnt   <= stop_ticks;
                end
                default: begin
                  tx_state <= TX_IDLE;
                  tx_idle  <= 1'b1;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  // Two-flop synchroniser plus one delay flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  // RX FSM and holding register: centre sampling, error capture, overrun on full holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state      <= RX_IDLE;
      rx_shift      <= '0;
      rx_perr       <= 1'b0;
      rx_cnt        <= '0;
      rx_bit        <= '0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (!cfg_rx_enable) begin
        rx_state <= RX_IDLE;
      end else begin
        case (rx_state)
          RX_IDLE: begin
            if (rx_fall) begin
              rx_state <= RX_START;
              rx_cnt   <= TICKS_HALF;
              rx_perr  <= 1'b0;
            end
          end
          default: begin
            if (tick) begin
              if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - 1'b1;
              end else begin
                rx_cnt <= TICKS_BIT;
                case (rx_state)
                  RX_START: begin
                    if (rxd_sync) begin
                      rx_state <= RX_IDLE;
                    end else begin
                      rx_state <= RX_DATA;
                      rx_bit   <= BIT_LAST;
                    end
                  end
                  RX_DATA: begin
                    rx_shift <= {rxd_sync, rx_shift[DATA_WIDTH-1:1]};
                    if (rx_bit != '0)              rx_bit   <= rx_bit - 1'b1;
                    else if (par_mode != PAR_NONE) rx_state <= RX_PARITY;
                    else                           rx_state <= RX_STOP;
                  end
                  RX_PARITY: begin
                    rx_perr  <= (rxd_sync != parity_bit(par_mode, ^rx_shift));
                    rx_state <= RX_STOP;
                  end
                  default: begin
                    rx_state <= RX_IDLE;
                    if (!rx_valid || rx_ready) begin
                      rx_data       <= rx_shift;
                      rx_parity_err <= rx_perr;
                      rx_frame_err  <= ~rxd_sync;
                      rx_valid      <= 1'b1;
                    end else begin
                      rx_overrun <= 1'b1;
                    end
                  end
                endcase
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_serdes.sv
// tb_uart_serdes: scenario bench for uart_serdes with a frame-level line model.
module tb_uart_serdes;

  localparam int DW      = 8;
  localparam int BIT_CYC = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_tx_enable, cfg_rx_enable, cfg_stop2;
  logic [1:0]    cfg_parity;
  logic [15:0]   cfg_baud_div;
  logic [DW-1:0] tx_data;
  logic          tx_valid, tx_ready, tx_busy, txd;
  logic          rxd, rxd_drv, loop_en;
  logic [DW-1:0] rx_data;
  logic          rx_valid, rx_ready, rx_parity_err, rx_frame_err, rx_overrun, rx_busy;

  int   checks = 0;
  int   passed = 0;
  logic exp_bits [0:15];
  int   exp_n;
  logic cap [0:2047];
  int   cap_n;
  int   ready_hi;
  int   ovr_cycles;

  assign rxd = loop_en ? txd : rxd_drv;

  always #5 clk = ~clk;

  uart_serdes #(.DATA_WIDTH(DW), .DIV_WIDTH(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_tx_enable (cfg_tx_enable),
    .cfg_rx_enable (cfg_rx_enable),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .cfg_baud_div  (cfg_baud_div),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_busy       (tx_busy),
    .txd           (txd),
    .rxd           (rxd),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .rx_overrun    (rx_overrun),
    .rx_busy       (rx_busy)
  );

  // Line model: list of bit levels for one character.
  task automatic build_frame(input logic [7:0] d, input logic [1:0] pm, input logic s2,
                             input logic par_flip, input logic stop_val);
    int ones;
    logic p;
    ones = $countones(d);
    exp_bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) exp_bits[1+i] = d[i];
    exp_n = 1 + DW;
    if (pm == 2'b01 || pm == 2'b10) begin
      p = (pm == 2'b10) ? (ones % 2 == 1) : (ones % 2 == 0);
      exp_bits[exp_n] = p ^ par_flip;
      exp_n++;
    end
    exp_bits[exp_n] = stop_val;
    exp_n++;
    if (s2) begin
      exp_bits[exp_n] = 1'b1;
      exp_n++;
    end
  endtask

  // Drive one character onto rxd from the bench, counting overrun pulses meanwhile.
  task automatic rx_drive(input logic [7:0] d, input logic [1:0] pm, input logic flip, input logic stop_val);
    build_frame(d, pm, 1'b0, flip, stop_val);
    @(negedge clk);
    for (int k = 0; k < exp_n; k++) begin
      rxd_drv = exp_bits[k];
      repeat (BIT_CYC) begin
        @(negedge clk);
        if (rx_overrun === 1'b1) ovr_cycles++;
      end
    end
    rxd_drv = 1'b1;
    repeat (16) begin
      @(negedge clk);
      if (rx_overrun === 1'b1) ovr_cycles++;
    end
  endtask

  // Scenario: send one character and check its line waveform bit by bit.
  task automatic test_tx_frame(input logic [7:0] d, input logic [1:0] pm, input logic s2, input string tag);
    int guard, s, bad, lo;
    cfg_parity = pm;
    cfg_stop2  = s2;
    build_frame(d, pm, s2, 1'b0, 1'b1);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    guard = 0;
    while (tx_ready !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    checks++; if (tx_ready !== 1'b1) $display("FAIL %s tx_accept: tx_ready=%b want 1", tag, tx_ready); else passed++;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    cap_n = 0;
    ready_hi = 0;
    @(negedge clk);
    while (tx_busy === 1'b1 && cap_n < 2048) begin
      cap[cap_n] = txd;
      if (tx_ready !== 1'b0) ready_hi++;
      cap_n++;
      @(negedge clk);
    end
    checks++;
    if (cap_n < BIT_CYC*exp_n - 3 || cap_n > BIT_CYC*exp_n)
      $display("FAIL %s frame_len: got %0d cycles want %0d..%0d", tag, cap_n, BIT_CYC*exp_n-3, BIT_CYC*exp_n);
    else passed++;
    checks++; if (ready_hi != 0) $display("FAIL %s ready_in_frame: tx_ready high %0d cycles want 0", tag, ready_hi); else passed++;
    checks++; if (tx_ready !== 1'b1) $display("FAIL %s ready_after_frame: got %b want 1", tag, tx_ready); else passed++;
    for (int k = 0; k < exp_n; k++) begin
      bad = 0;
      lo = (k == 0) ? 0 : BIT_CYC*k;
      for (int c = lo; c <= lo + 60; c++)
        if (c >= cap_n || cap[c] !== exp_bits[k]) bad++;
      checks++;
      if (bad != 0) $display("FAIL %s bit%0d: %0d cycles not at required level %b", tag, k, bad, exp_bits[k]);
      else passed++;
    end
    if (exp_bits[1] === 1'b1) begin
      s = 0;
      while (s < cap_n && cap[s] === 1'b0) s++;
      checks++; if (s < 61 || s > 64) $display("FAIL %s start_len: got %0d want 61..64", tag, s); else passed++;
    end
  endtask

  // Scenario: wait for one received character, check it, then drain it.
  task automatic test_rx_char(input logic [7:0] d, input logic pe, input logic fe, input string tag);
    int guard;
    guard = 0;
    while (rx_valid !== 1'b1 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    checks++; if (rx_valid !== 1'b1) $display("FAIL %s rx_valid_timeout: got %b want 1", tag, rx_valid); else passed++;
    checks++; if (rx_data !== d) $display("FAIL %s rx_data: got %h want %h", tag, rx_data, d); else passed++;
    checks++; if (rx_parity_err !== pe) $display("FAIL %s parity_err: got %b want %b", tag, rx_parity_err, pe); else passed++;
    checks++; if (rx_frame_err !== fe) $display("FAIL %s frame_err: got %b want %b", tag, rx_frame_err, fe); else passed++;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    checks++; if (rx_valid !== 1'b0) $display("FAIL %s rx_valid_clear: got %b want 0", tag, rx_valid); else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg_tx_enable = 1'b1; cfg_rx_enable = 1'b1; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    cfg_baud_div = 16'd3; tx_data = '0; tx_valid = 1'b0; rxd_drv = 1'b1; loop_en = 1'b0; rx_ready = 1'b0;
    ovr_cycles = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({txd, tx_ready, tx_busy, rx_busy, rx_valid, rx_overrun, rx_parity_err, rx_frame_err, rx_data} !== {1'b1, 7'b0, 8'h00})
      $display("FAIL reset_outputs: got %b want %b",
               {txd, tx_ready, tx_busy, rx_busy, rx_valid, rx_overrun, rx_parity_err, rx_frame_err, rx_data}, {1'b1, 7'b0, 8'h00});
    else passed++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (tx_ready !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", tx_ready); else passed++;
  endtask

  task automatic test_tx_a5();
    loop_en = 1'b0;
    test_tx_frame(8'hA5, 2'b00, 1'b0, "tx_a5");
  endtask

  task automatic test_loopback();
    logic [7:0] d;
    logic [1:0] pm;
    logic s2;
    loop_en = 1'b1;
    test_tx_frame(8'h07, 2'b10, 1'b0, "lb_07");
    test_rx_char(8'h07, 1'b0, 1'b0, "lb_07");
    test_tx_frame(8'h00, 2'b10, 1'b0, "lb_00");
    test_rx_char(8'h00, 1'b0, 1'b0, "lb_00");
    for (int i = 0; i < 4; i++) begin
      d  = 8'($urandom);
      pm = 2'($urandom_range(0, 3));
      s2 = 1'($urandom_range(0, 1));
      test_tx_frame(d, pm, s2, "lb_rand");
      test_rx_char(d, 1'b0, 1'b0, "lb_rand");
    end
    loop_en = 1'b0;
  endtask

  task automatic test_errors();
    logic [7:0] d;
    cfg_stop2 = 1'b0;
    cfg_parity = 2'b00;
    d = 8'($urandom);
    rx_drive(d, 2'b00, 1'b0, 1'b0);
    test_rx_char(d, 1'b0, 1'b1, "frame_err");
    cfg_parity = 2'b01;
    d = 8'($urandom);
    rx_drive(d, 2'b01, 1'b1, 1'b1);
    test_rx_char(d, 1'b1, 1'b0, "parity_err");
    d = 8'($urandom);
    rx_drive(d, 2'b01, 1'b0, 1'b1);
    test_rx_char(d, 1'b0, 1'b0, "parity_ok");
    cfg_parity = 2'b00;
  endtask

  task automatic test_overrun();
    rx_ready = 1'b0;
    ovr_cycles = 0;
    rx_drive(8'h11, 2'b00, 1'b0, 1'b1);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) $display("FAIL ovr_first: valid=%b data=%h want 1/11", rx_valid, rx_data); else passed++;
    rx_drive(8'h22, 2'b00, 1'b0, 1'b1);
    checks++; if (rx_data !== 8'h11) $display("FAIL ovr_hold: got %h want 11", rx_data); else passed++;
    checks++; if (ovr_cycles != 1) $display("FAIL ovr_pulse: got %0d cycles want 1", ovr_cycles); else passed++;
    checks++; if (rx_valid !== 1'b1) $display("FAIL ovr_valid: got %b want 1", rx_valid); else passed++;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    checks++; if (rx_valid !== 1'b0) $display("FAIL ovr_drain: got %b want 0", rx_valid); else passed++;
  endtask

  task automatic test_glitch_abort();
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (rx_busy !== 1'b1) $display("FAIL glitch_busy: got %b want 1", rx_busy); else passed++;
    repeat (10) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (80) @(negedge clk);
    checks++; if (rx_busy !== 1'b0 || rx_valid !== 1'b0) $display("FAIL glitch_idle: busy=%b valid=%b want 0/0", rx_busy, rx_valid); else passed++;
    rxd_drv = 1'b0;
    repeat (150) @(negedge clk);
    checks++; if (rx_busy !== 1'b1) $display("FAIL abort_busy: got %b want 1", rx_busy); else passed++;
    cfg_rx_enable = 1'b0;
    @(negedge clk);
    checks++; if (rx_busy !== 1'b0) $display("FAIL abort_idle: got %b want 0", rx_busy); else passed++;
    repeat (200) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (100) @(negedge clk);
    cfg_rx_enable = 1'b1;
    repeat (100) @(negedge clk);
    checks++; if (rx_valid !== 1'b0 || rx_busy !== 1'b0) $display("FAIL abort_no_output: valid=%b busy=%b want 0/0", rx_valid, rx_busy); else passed++;
  endtask

  task automatic test_reset_mid_tx();
    logic [7:0] d;
    int guard;
    loop_en = 1'b0;
    cfg_parity = 2'b00;
    cfg_stop2 = 1'b0;
    d = 8'($urandom) & 8'hFB;
    @(negedge clk);
    tx_data = d;
    tx_valid = 1'b1;
    guard = 0;
    while (tx_ready !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 tx_valid = 1'b0;
    repeat (200) @(negedge clk);
    checks++; if (txd !== 1'b0) $display("FAIL midtx_bit2: got %b want 0", txd); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({txd, tx_ready, tx_busy, rx_busy, rx_valid, rx_overrun, rx_parity_err, rx_frame_err, rx_data} !== {1'b1, 7'b0, 8'h00})
      $display("FAIL midtx_reset_outputs: got %b want %b",
               {txd, tx_ready, tx_busy, rx_busy, rx_valid, rx_overrun, rx_parity_err, rx_frame_err, rx_data}, {1'b1, 7'b0, 8'h00});
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_tx_frame(8'h3C, 2'b00, 1'b0, "post_reset_3c");
  endtask

  initial begin
    test_reset();
    test_tx_a5();
    test_loopback();
    test_errors();
    test_overrun();
    test_glitch_abort();
    test_reset_mid_tx();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
